// File: rtl/csa_operand_collector.sv
// rtl/csa_operand_collector.sv - buffers an operand group and sums it through a carry-save adder tree

// Carry-save reduction of M unsigned N-bit operands into a W-bit {Cout, Sum} total.
module csa #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic [N-1:0]     operands_i [M],
  output logic             cout_o,
  output logic [N+M-3:0]   sum_o
);

  localparam int W = N + M - 1;

  logic [W-1:0] s_acc;
  logic [W-1:0] c_acc;
  logic [W-1:0] s_nxt;
  logic [W-1:0] op_ext;
  logic [W-1:0] total;

  // 3:2 compress one operand at a time into the sum/carry pair, then resolve with a final add.
  // The true sum is below 2^W, so dropping carries past bit W-1 cannot change the result.
  always_comb begin
    s_acc  = W'(operands_i[0]);
    c_acc  = W'(operands_i[1]);
    s_nxt  = '0;
    op_ext = '0;
    for (int i = 2; i < M; i++) begin
      op_ext = W'(operands_i[i]);
      s_nxt  = s_acc ^ c_acc ^ op_ext;
      c_acc  = ((s_acc & c_acc) | (s_acc & op_ext) | (c_acc & op_ext)) << 1;
      s_acc  = s_nxt;
    end
    total = s_acc + c_acc;
  end

  assign {cout_o, sum_o} = total;

endmodule

// Operand collector: FILL accepts up to M operands, CALC registers the tree output, DONE holds it.
module csa_operand_collector #(
  parameter int M = 8,
  parameter int N = 4,
  localparam int W = N + M - 1,
  localparam int C = $clog2(M + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [C-1:0] out_count
);

  localparam int IW = $clog2(M);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [C-1:0] idx_q;
  logic [N-1:0] slot_q [M];
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] out_sum_q;
  logic [C-1:0] out_count_q;

  logic         csa_cout;
  logic [W-2:0] csa_sum;
  logic [W-1:0] sum_d;

  csa #(
    .M(M),
    .N(N)
  ) u_csa (
    .operands_i(slot_q),
    .cout_o    (csa_cout),
    .sum_o     (csa_sum)
  );

  assign sum_d = {csa_cout, csa_sum};

  // Group sequencing; in_ready/out_valid are registered so neither depends on in_valid/out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      for (int i = 0; i < M; i++) slot_q[i] <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          // in_ready comes up one edge after reset release and stays up while filling.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            slot_q[idx_q[IW-1:0]] <= in_data;
            idx_q                 <= idx_q + C'(1);
            if ((idx_q == C'(M - 1)) || in_last) begin
              state_q    <= S_CALC;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_CALC: begin
          out_sum_q   <= sum_d;
          out_count_q <= idx_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          // Slots are zeroed on handoff so a following short group is zero-padded.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            for (int i = 0; i < M; i++) slot_q[i] <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= S_FILL;
          end
        end
        default: begin
          state_q     <= S_FILL;
          idx_q       <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule
